// File: rtl/bcd_entry_if.sv
// Keypad-side command strobes and entry/memory outputs of the BCD entry register.
// Every command is a 1-cycle strobe sampled on the rising clock edge; there is no backpressure.
interface bcd_entry_if #(
  parameter int DIGITS = 3,
  parameter int CW     = $clog2(DIGITS + 1)
) ();
  logic                  enable;
  logic                  clear;
  logic                  digit_valid;
  logic [3:0]            digit;
  logic                  backspace;
  logic                  negate;
  logic                  store;
  logic                  recall;
  logic [4*DIGITS-1:0]   value;
  logic                  negative;
  logic [CW-1:0]         digit_count;
  logic                  full;
  logic                  overflow;
  logic                  bad_digit;
  logic [4*DIGITS-1:0]   mem_value;
  logic                  mem_negative;

  modport master (
    output enable, clear, digit_valid, digit, backspace, negate, store, recall,
    input  value, negative, digit_count, full, overflow, bad_digit, mem_value, mem_negative
  );

  modport slave (
    input  enable, clear, digit_valid, digit, backspace, negate, store, recall,
    output value, negative, digit_count, full, overflow, bad_digit, mem_value, mem_negative
  );
endinterface

// File: rtl/bcd_entry_register.sv
// Packed-BCD keypad entry register with sign, significant-digit count and a one-deep memory.
// Edits are applied one at a time by priority; store runs alongside and sees the pre-edit entry.
module bcd_entry_register #(
  parameter int DIGITS = 3,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic         clock,
  input  logic         reset,
  bcd_entry_if.slave   bus
);

  localparam int VW = 4 * DIGITS;

  logic [VW-1:0] value_q, value_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          bad_q, bad_d;
  logic [VW-1:0] mem_q, mem_d;
  logic          mem_neg_q, mem_neg_d;
  logic          full;
  logic [VW-1:0] shifted;

  function automatic logic [CW-1:0] sig_digits(input logic [VW-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0) c = CW'(i + 1);
    end
    return c;
  endfunction

  assign full = (count_q == CW'(DIGITS));

  always_comb begin
    value_d   = value_q;
    neg_d     = neg_q;
    count_d   = count_q;
    ovf_d     = 1'b0;
    bad_d     = 1'b0;
    mem_d     = mem_q;
    mem_neg_d = mem_neg_q;
    shifted   = value_q >> 4;

    if (bus.enable && bus.store) begin
      mem_d     = value_q;
      mem_neg_d = neg_q;
    end

    if (!bus.enable || bus.clear) begin
      value_d = '0;
      neg_d   = 1'b0;
      count_d = '0;
    end else if (bus.recall) begin
      value_d = mem_q;
      neg_d   = mem_neg_q;
      count_d = sig_digits(mem_q);
    end else if (bus.backspace) begin
      value_d = shifted;
      count_d = (count_q == '0) ? '0 : count_q - 1'b1;
      // Zero is never negative, so dropping the last digit also drops the sign.
      if (shifted == '0) neg_d = 1'b0;
    end else if (bus.digit_valid) begin
      if (bus.digit > 4'd9) begin
        bad_d = 1'b1;
      end else if (full) begin
        ovf_d = 1'b1;
      end else if (!(count_q == '0 && bus.digit == 4'd0)) begin
        value_d = (value_q << 4) | VW'(bus.digit);
        count_d = count_q + 1'b1;
      end
    end else if (bus.negate) begin
      if (value_q != '0) neg_d = ~neg_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q   <= '0;
      neg_q     <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
      mem_q     <= '0;
      mem_neg_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      neg_q     <= neg_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
      mem_q     <= mem_d;
      mem_neg_q <= mem_neg_d;
    end
  end

  assign bus.value        = value_q;
  assign bus.negative     = neg_q;
  assign bus.digit_count  = count_q;
  assign bus.full         = full;
  assign bus.overflow     = ovf_q;
  assign bus.bad_digit    = bad_q;
  assign bus.mem_value    = mem_q;
  assign bus.mem_negative = mem_neg_q;

endmodule

// File: tb/tb_bcd_entry_register.sv
// Scenario bench for bcd_entry_register: a 3-digit and a 5-digit instance driven from stimulus
// tables, expected outputs queued at drive time and compared after the edge.
module tb_bcd_entry_register;

  localparam logic [6:0] S_NOP = 7'd0;
  localparam logic [6:0] S_DIG = 7'd1;
  localparam logic [6:0] S_NEG = 7'd2;
  localparam logic [6:0] S_BS  = 7'd4;
  localparam logic [6:0] S_CLR = 7'd8;
  localparam logic [6:0] S_RCL = 7'd16;
  localparam logic [6:0] S_STO = 7'd32;
  localparam logic [6:0] S_DIS = 7'd64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [30:0] exp_q[$];
  logic [47:0] exp5_q[$];

  always #5 clock = ~clock;

  bcd_entry_if #(.DIGITS(3)) if3 ();
  bcd_entry_if #(.DIGITS(5)) if5 ();

  bcd_entry_register #(.DIGITS(3)) dut3 (.clock(clock), .reset(reset), .bus(if3));
  bcd_entry_register #(.DIGITS(5)) dut5 (.clock(clock), .reset(reset), .bus(if5));

  function automatic logic [30:0] obs3();
    return {if3.mem_value, if3.mem_negative, if3.value, if3.negative,
            if3.digit_count, if3.full, if3.overflow, if3.bad_digit};
  endfunction

  function automatic logic [47:0] obs5();
    return {if5.mem_value, if5.mem_negative, if5.value, if5.negative,
            if5.digit_count, if5.full, if5.overflow, if5.bad_digit};
  endfunction

  function automatic logic [30:0] ev(input logic [11:0] mv, input logic mn, input logic [11:0] v,
                                     input logic n, input logic [1:0] c, input logic o, input logic b);
    return {mv, mn, v, n, c, (c == 2'd3), o, b};
  endfunction

  function automatic logic [47:0] ev5(input logic [19:0] v, input logic [2:0] c, input logic o);
    return {20'h0, 1'b0, v, 1'b0, c, (c == 3'd5), o, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive3(input logic [6:0] m, input logic [3:0] d);
    if3.digit_valid = m[0];
    if3.negate      = m[1];
    if3.backspace   = m[2];
    if3.clear       = m[3];
    if3.recall      = m[4];
    if3.store       = m[5];
    if3.enable      = ~m[6];
    if3.digit       = d;
  endtask

  task automatic drive5(input logic [6:0] m, input logic [3:0] d);
    if5.digit_valid = m[0];
    if5.negate      = m[1];
    if5.backspace   = m[2];
    if5.clear       = m[3];
    if5.recall      = m[4];
    if5.store       = m[5];
    if5.enable      = ~m[6];
    if5.digit       = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    drive3(S_NOP, 4'd0);
    drive5(S_NOP, 4'd0);
  endtask

  // ---------------- invariant monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      logic ok3, ok5;
      ok3 = !(if3.negative && if3.value == '0) && !(if3.overflow && if3.bad_digit);
      for (int i = 0; i < 3; i++)
        if (i >= int'(if3.digit_count) && if3.value[4*i +: 4] != 4'd0) ok3 = 1'b0;
      ok5 = !(if5.negative && if5.value == '0) && !(if5.overflow && if5.bad_digit);
      for (int i = 0; i < 5; i++)
        if (i >= int'(if5.digit_count) && if5.value[4*i +: 4] != 4'd0) ok5 = 1'b0;
      checks += 2;
      if (!ok3) begin
        errors++;
        $display("FAIL invariant3 t=%0t value=%h neg=%b count=%0d ovf=%b bad=%b required=consistent",
                 $time, if3.value, if3.negative, if3.digit_count, if3.overflow, if3.bad_digit);
      end
      if (!ok5) begin
        errors++;
        $display("FAIL invariant5 t=%0t value=%h neg=%b count=%0d ovf=%b bad=%b required=consistent",
                 $time, if5.value, if5.negative, if5.digit_count, if5.overflow, if5.bad_digit);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [30:0] got;
    logic [47:0] got5;
    reset = 1'b0;
    repeat (3) tick();
    got = obs3();
    got5 = obs5();
    checks++;
    if (got !== 31'd0) begin
      errors++;
      $display("FAIL reset3 got=%h exp=%h", got, 31'd0);
    end
    checks++;
    if (got5 !== 48'd0) begin
      errors++;
      $display("FAIL reset5 got=%h exp=%h", got5, 48'd0);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_digit_entry();
    logic [6:0]  m[6];
    logic [3:0]  d[6];
    logic [30:0] e[6];
    logic [30:0] got, exp;
    m = '{S_CLR, S_DIG, S_DIG, S_DIG, S_DIG, S_NOP};
    d = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    e = '{ev(12'h0, 0, 12'h000, 0, 2'd0, 0, 0), ev(12'h0, 0, 12'h001, 0, 2'd1, 0, 0),
          ev(12'h0, 0, 12'h012, 0, 2'd2, 0, 0), ev(12'h0, 0, 12'h123, 0, 2'd3, 0, 0),
          ev(12'h0, 0, 12'h123, 0, 2'd3, 1, 0), ev(12'h0, 0, 12'h123, 0, 2'd3, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(e[i]);
      drive3(m[i], d[i]);
      tick();
      got = obs3();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL digit_entry[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_leading_zero_bad_digit();
    logic [6:0]  m[8];
    logic [3:0]  d[8];
    logic [30:0] e[8];
    logic [30:0] got, exp;
    m = '{S_CLR, S_DIG, S_DIG, S_DIG, S_DIG, S_NOP, S_DIG | S_NEG, S_NEG};
    d = '{4'd0, 4'd0, 4'd0, 4'd7, 4'hB, 4'd0, 4'hC, 4'd0};
    e = '{ev(12'h0, 0, 12'h000, 0, 2'd0, 0, 0), ev(12'h0, 0, 12'h000, 0, 2'd0, 0, 0),
          ev(12'h0, 0, 12'h000, 0, 2'd0, 0, 0), ev(12'h0, 0, 12'h007, 0, 2'd1, 0, 0),
          ev(12'h0, 0, 12'h007, 0, 2'd1, 0, 1), ev(12'h0, 0, 12'h007, 0, 2'd1, 0, 0),
          ev(12'h0, 0, 12'h007, 0, 2'd1, 0, 1), ev(12'h0, 0, 12'h007, 1, 2'd1, 0, 0)};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(e[i]);
      drive3(m[i], d[i]);
      tick();
      got = obs3();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL leading_zero_bad_digit[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_backspace_negate();
    logic [6:0]  m[10];
    logic [3:0]  d[10];
    logic [30:0] e[10];
    logic [30:0] got, exp;
    m = '{S_CLR, S_DIG, S_DIG, S_DIG, S_NEG, S_BS, S_BS, S_BS, S_BS, S_NEG};
    d = '{4'd0, 4'd4, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    e = '{ev(12'h0, 0, 12'h000, 0, 2'd0, 0, 0), ev(12'h0, 0, 12'h004, 0, 2'd1, 0, 0),
          ev(12'h0, 0, 12'h045, 0, 2'd2, 0, 0), ev(12'h0, 0, 12'h450, 0, 2'd3, 0, 0),
          ev(12'h0, 0, 12'h450, 1, 2'd3, 0, 0), ev(12'h0, 0, 12'h045, 1, 2'd2, 0, 0),
          ev(12'h0, 0, 12'h004, 1, 2'd1, 0, 0), ev(12'h0, 0, 12'h000, 0, 2'd0, 0, 0),
          ev(12'h0, 0, 12'h000, 0, 2'd0, 0, 0), ev(12'h0, 0, 12'h000, 0, 2'd0, 0, 0)};
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(e[i]);
      drive3(m[i], d[i]);
      tick();
      got = obs3();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL backspace_negate[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_store_recall();
    logic [6:0]  m[8];
    logic [3:0]  d[8];
    logic [30:0] e[8];
    logic [30:0] got, exp;
    m = '{S_CLR, S_DIG, S_DIG, S_NEG, S_STO, S_CLR, S_RCL, S_RCL | S_BS};
    d = '{4'd0, 4'd8, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    e = '{ev(12'h000, 0, 12'h000, 0, 2'd0, 0, 0), ev(12'h000, 0, 12'h008, 0, 2'd1, 0, 0),
          ev(12'h000, 0, 12'h089, 0, 2'd2, 0, 0), ev(12'h000, 0, 12'h089, 1, 2'd2, 0, 0),
          ev(12'h089, 1, 12'h089, 1, 2'd2, 0, 0), ev(12'h089, 1, 12'h000, 0, 2'd0, 0, 0),
          ev(12'h089, 1, 12'h089, 1, 2'd2, 0, 0), ev(12'h089, 1, 12'h089, 1, 2'd2, 0, 0)};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(e[i]);
      drive3(m[i], d[i]);
      tick();
      got = obs3();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL store_recall[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [6:0]  m[6];
    logic [3:0]  d[6];
    logic [30:0] e[6];
    logic [30:0] got, exp;
    m = '{S_CLR, S_DIG, S_DIG, S_STO | S_DIG, S_CLR | S_RCL | S_DIG, S_RCL};
    d = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd7, 4'd0};
    e = '{ev(12'h089, 1, 12'h000, 0, 2'd0, 0, 0), ev(12'h089, 1, 12'h001, 0, 2'd1, 0, 0),
          ev(12'h089, 1, 12'h012, 0, 2'd2, 0, 0), ev(12'h012, 0, 12'h125, 0, 2'd3, 0, 0),
          ev(12'h012, 0, 12'h000, 0, 2'd0, 0, 0), ev(12'h012, 0, 12'h012, 0, 2'd2, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(e[i]);
      drive3(m[i], d[i]);
      tick();
      got = obs3();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL same_cycle[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset_enable();
    logic [6:0]  m[6];
    logic [3:0]  d[6];
    logic [30:0] e[6];
    logic [30:0] got, exp;
    logic [47:0] got5;
    drive3(S_CLR, 4'd0); tick();
    drive3(S_DIG, 4'd3); tick();
    drive3(S_DIG, 4'd1); tick();
    // Assert reset between edges and look before the next rising edge.
    #2;
    reset = 1'b0;
    #1;
    got = obs3();
    got5 = obs5();
    checks++;
    if (got !== 31'd0) begin
      errors++;
      $display("FAIL async_reset3 got=%h exp=%h", got, 31'd0);
    end
    checks++;
    if (got5 !== 48'd0) begin
      errors++;
      $display("FAIL async_reset5 got=%h exp=%h", got5, 48'd0);
    end
    drive3(S_DIG, 4'd9);
    tick();
    got = obs3();
    checks++;
    if (got !== 31'd0) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", got, 31'd0);
    end
    reset = 1'b1;
    m = '{S_DIG, S_DIG, S_STO, S_DIG, S_DIS | S_STO, S_NOP};
    d = '{4'd3, 4'd1, 4'd0, 4'd5, 4'd0, 4'd0};
    e = '{ev(12'h000, 0, 12'h003, 0, 2'd1, 0, 0), ev(12'h000, 0, 12'h031, 0, 2'd2, 0, 0),
          ev(12'h031, 0, 12'h031, 0, 2'd2, 0, 0), ev(12'h031, 0, 12'h315, 0, 2'd3, 0, 0),
          ev(12'h031, 0, 12'h000, 0, 2'd0, 0, 0), ev(12'h031, 0, 12'h000, 0, 2'd0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(e[i]);
      drive3(m[i], d[i]);
      tick();
      got = obs3();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL enable_clear[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_digits5();
    logic [6:0]  m[8];
    logic [3:0]  d[8];
    logic [47:0] e[8];
    logic [47:0] got, exp;
    m = '{S_CLR, S_DIG, S_DIG, S_DIG, S_DIG, S_DIG, S_DIG, S_NOP};
    d = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0};
    e = '{ev5(20'h00000, 3'd0, 0), ev5(20'h00001, 3'd1, 0), ev5(20'h00012, 3'd2, 0),
          ev5(20'h00123, 3'd3, 0), ev5(20'h01234, 3'd4, 0), ev5(20'h12345, 3'd5, 0),
          ev5(20'h12345, 3'd5, 1), ev5(20'h12345, 3'd5, 0)};
    for (int i = 0; i < 8; i++) begin
      exp5_q.push_back(e[i]);
      drive5(m[i], d[i]);
      tick();
      got = obs5();
      exp = exp5_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL digits5[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    drive3(S_NOP, 4'd0);
    drive5(S_NOP, 4'd0);
    test_reset();
    test_digit_entry();
    test_leading_zero_bad_digit();
    test_backspace_negate();
    test_store_recall();
    test_same_cycle();
    test_async_reset_enable();
    test_digits5();
    if (exp_q.size() != 0 || exp5_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size() + exp5_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
